// File: rtl/cmd_parser_pkg.sv
// Shared types and constants for the host-link command parser.
package cmd_parser_pkg;

  // Packet framing phases.
  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    LEN,
    DATA
  } state_t;

  localparam logic [7:0] SYNC_BYTE  = 8'hAA;
  localparam int         N_ADDR_DEF = 21;

  // Width of an index into a bus of n strobes (at least one bit).
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ADDR_W = addr_width(N_ADDR_DEF);

endpackage

// File: rtl/cmd_parser_if.sv
// Byte-stream input and register-bank write-strobe output of cmd_parser.
interface cmd_parser_if
  import cmd_parser_pkg::*;
#(
  parameter int N_ADDR = N_ADDR_DEF
) ();

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        master_data;
  logic [N_ADDR-1:0] valid_bus;
  logic              busy;
  logic              err_addr;
  logic              err_timeout;

  // Host side: supplies bytes, observes strobes and status.
  modport master (
    output rx_data, rx_valid,
    input  master_data, valid_bus, busy, err_addr, err_timeout
  );

  // Parser side.
  modport slave (
    input  rx_data, rx_valid,
    output master_data, valid_bus, busy, err_addr, err_timeout
  );

endinterface

// File: rtl/cmd_parser_byte_timeout.sv
// Inter-byte idle counter; flags a packet that stalls for too long.
module byte_timeout #(
  parameter int TIMEOUT = 50000
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 2);

  logic [CW-1:0] cnt_q;

  // expired is decoded one count early so that the owner reacts on the same
  // edge where the count would reach TIMEOUT-1; a byte on that edge (clear)
  // suppresses it.
  always_comb begin
    expired = enable && !clear && (cnt_q == LAST);
  end

  // Idle counter: zero outside a packet or on any byte, otherwise counts up.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else if (clear || !enable || expired) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/cmd_parser.sv
// Frames SYNC/ADDR/LEN/payload packets and replays payload as write strobes.
module cmd_parser
  import cmd_parser_pkg::*;
#(
  parameter int         N_ADDR  = N_ADDR_DEF,
  parameter logic [7:0] SYNC    = SYNC_BYTE,
  parameter int         TIMEOUT = 50000
) (
  input  logic         clk,
  input  logic         n_rst,
  cmd_parser_if.slave  bus
);

  localparam int         AW         = addr_width(N_ADDR);
  localparam logic [8:0] ADDR_LIMIT = 9'(N_ADDR);
  localparam logic [N_ADDR-1:0] ONE = {{(N_ADDR-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [7:0]        rem_q, rem_d;
  logic              drop_q, drop_d;
  logic [7:0]        data_q, data_d;
  logic [N_ADDR-1:0] vbus_q, vbus_d;
  logic              eaddr_q, eaddr_d;
  logic              eto_q, eto_d;
  logic              in_pkt;
  logic              expired;
  logic              bad_addr;

  assign in_pkt   = (state_q != IDLE);
  assign bad_addr = ({1'b0, bus.rx_data} >= ADDR_LIMIT);

  byte_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (bus.rx_valid),
    .enable  (in_pkt),
    .expired (expired)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, latches and next output values; an accepted byte overrides
  // a timeout because expired is already gated by rx_valid.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    drop_d  = drop_q;
    data_d  = data_q;
    vbus_d  = '0;
    eaddr_d = 1'b0;
    eto_d   = 1'b0;
    if (bus.rx_valid) begin
      unique case (state_q)
        IDLE: begin
          if (bus.rx_data == SYNC) begin
            state_d = ADDR;
          end
        end
        ADDR: begin
          addr_d  = bus.rx_data[AW-1:0];
          drop_d  = bad_addr;
          eaddr_d = bad_addr;
          state_d = LEN;
        end
        LEN: begin
          if (bus.rx_data == 8'd0) begin
            drop_d  = 1'b0;
            state_d = IDLE;
          end else begin
            rem_d   = bus.rx_data;
            state_d = DATA;
          end
        end
        DATA: begin
          data_d = bus.rx_data;
          if (!drop_q) begin
            vbus_d = ONE << addr_q;
          end
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            drop_d  = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (expired) begin
      drop_d  = 1'b0;
      eto_d   = 1'b1;
      state_d = IDLE;
    end
  end

  // Latches and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      addr_q  <= '0;
      rem_q   <= '0;
      drop_q  <= 1'b0;
      data_q  <= '0;
      vbus_q  <= '0;
      eaddr_q <= 1'b0;
      eto_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      drop_q  <= drop_d;
      data_q  <= data_d;
      vbus_q  <= vbus_d;
      eaddr_q <= eaddr_d;
      eto_q   <= eto_d;
    end
  end

  assign bus.master_data = data_q;
  assign bus.valid_bus   = vbus_q;
  assign bus.busy        = in_pkt;
  assign bus.err_addr    = eaddr_q;
  assign bus.err_timeout = eto_q;

endmodule

// File: tb/tb_cmd_parser.sv
// Self-checking bench for cmd_parser: directed scenarios plus random packet
// streams scored against a packet-level expectation queue.
module tb_cmd_parser;

  localparam int         N_ADDR  = 21;
  localparam int         TIMEOUT = 24;
  localparam logic [7:0] SYNC    = 8'hAA;

  logic clk = 1'b0;
  logic n_rst = 1'b0;

  always #5 clk = ~clk;

  cmd_parser_if #(.N_ADDR(N_ADDR)) bus ();

  cmd_parser #(
    .N_ADDR  (N_ADDR),
    .SYNC    (SYNC),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Expected strobes in order: {address, data}.
  logic [15:0] exp_q[$];
  logic [15:0] mon_e;
  int exp_eaddr = 0;
  int exp_eto   = 0;
  int obs_eaddr = 0;
  int obs_eto   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe must match the next expected payload byte.
  always @(negedge clk) begin
    if (n_rst) begin
      if (bus.valid_bus != '0) begin
        check("strobe_onehot", 32'($onehot(bus.valid_bus)), 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 32'(bus.valid_bus), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("strobe_bus", 32'(bus.valid_bus), 32'd1 << mon_e[15:8]);
          check("strobe_data", 32'(bus.master_data), 32'(mon_e[7:0]));
        end
      end
      if (bus.err_addr)    obs_eaddr++;
      if (bus.err_timeout) obs_eto++;
    end
  end

  task automatic send(input logic [7:0] d);
    bus.rx_valid = 1'b1;
    bus.rx_data  = d;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.rx_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int a, input logic [7:0] d);
    exp_q.push_back({8'(a), d});
  endtask

  // Sends one packet; cut > 0 truncates it after that many bytes and then
  // stalls long enough to force a timeout.
  task automatic rand_packet(input int a, input int len, input int cut, input bit slow);
    int b[$];
    int n;
    int gap;
    b.push_back(int'(SYNC));
    b.push_back(a);
    b.push_back(len);
    for (int i = 0; i < len; i++) b.push_back(int'($urandom_range(0, 255)));
    n = (cut > 0) ? cut : b.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0 && slow) begin
        gap = ($urandom_range(0, 3) == 0) ? TIMEOUT - 2 : int'($urandom_range(0, 3));
        idle(gap);
      end
      send(8'(b[i]));
      if (i == 1 && a >= N_ADDR) exp_eaddr++;
      if (i >= 3 && a < N_ADDR) push(a, 8'(b[i]));
    end
    if (cut > 0) begin
      idle(TIMEOUT - 1 + int'($urandom_range(0, 3)));
      exp_eto++;
    end
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;
    idle(1);

    check("rst_data", 32'(bus.master_data), 32'd0);
    check("rst_vbus", 32'(bus.valid_bus), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_eaddr", 32'(bus.err_addr), 32'd0);
    check("rst_eto", 32'(bus.err_timeout), 32'd0);

    // Single-byte packet to address 11.
    push(11, 8'h05);
    send(8'hAA);
    check("t1_busy_rise", 32'(bus.busy), 32'd1);
    send(8'h0B);
    send(8'h01);
    check("t1_busy_mid", 32'(bus.busy), 32'd1);
    send(8'h05);
    check("t1_vbus", 32'(bus.valid_bus), 32'd1 << 11);
    check("t1_data", 32'(bus.master_data), 32'h05);
    check("t1_busy_fall", 32'(bus.busy), 32'd0);
    idle(1);
    check("t1_vbus_clear", 32'(bus.valid_bus), 32'd0);
    check("t1_data_hold", 32'(bus.master_data), 32'h05);

    // Full-rate three-byte packet, then an empty packet straight after.
    push(12, 8'h11); push(12, 8'h22); push(12, 8'h33);
    send(8'hAA); send(8'h0C); send(8'h03);
    send(8'h11);
    check("t2_vbus0", 32'(bus.valid_bus), 32'd1 << 12);
    check("t2_data0", 32'(bus.master_data), 32'h11);
    send(8'h22);
    check("t2_vbus1", 32'(bus.valid_bus), 32'd1 << 12);
    check("t2_data1", 32'(bus.master_data), 32'h22);
    send(8'h33);
    check("t2_data2", 32'(bus.master_data), 32'h33);
    check("t2_busy_end", 32'(bus.busy), 32'd0);
    send(8'hAA);
    check("t2_b2b_busy", 32'(bus.busy), 32'd1);
    check("t2_b2b_vbus", 32'(bus.valid_bus), 32'd0);
    send(8'h0D);
    send(8'h00);
    check("t2_len0_busy", 32'(bus.busy), 32'd0);
    check("t2_len0_vbus", 32'(bus.valid_bus), 32'd0);

    // Leading junk, then a bad-address packet, then a good one.
    send(8'h00);
    check("t3_junk_busy", 32'(bus.busy), 32'd0);
    send(8'hFF);
    send(8'hAA);
    send(8'h15);
    exp_eaddr++;
    check("t3_eaddr", 32'(bus.err_addr), 32'd1);
    send(8'h02);
    check("t3_eaddr_pulse", 32'(bus.err_addr), 32'd0);
    send(8'h01);
    send(8'h02);
    check("t3_drop_busy", 32'(bus.busy), 32'd0);
    check("t3_drop_vbus", 32'(bus.valid_bus), 32'd0);
    push(16, 8'h01);
    send(8'hAA); send(8'h10); send(8'h01); send(8'h01);
    check("t3_good_vbus", 32'(bus.valid_bus), 32'd1 << 16);

    // Stall mid-packet until timeout.
    push(19, 8'h01);
    send(8'hAA); send(8'h13); send(8'h02); send(8'h01);
    check("t4_vbus", 32'(bus.valid_bus), 32'd1 << 19);
    exp_eto++;
    for (int p = 1; p <= TIMEOUT; p++) begin
      idle(1);
      if (p == TIMEOUT - 2) begin
        check("t4_busy_before", 32'(bus.busy), 32'd1);
        check("t4_eto_before", 32'(bus.err_timeout), 32'd0);
      end
      if (p == TIMEOUT - 1) begin
        check("t4_eto", 32'(bus.err_timeout), 32'd1);
        check("t4_busy_after", 32'(bus.busy), 32'd0);
      end
      if (p == TIMEOUT) check("t4_eto_pulse", 32'(bus.err_timeout), 32'd0);
    end
    push(19, 8'h00);
    send(8'hAA); send(8'h13); send(8'h01); send(8'h00);
    check("t4_next_vbus", 32'(bus.valid_bus), 32'd1 << 19);
    check("t4_next_data", 32'(bus.master_data), 32'h00);

    // Byte arriving on the last permitted idle cycle wins over timeout.
    push(5, 8'h44); push(5, 8'h55);
    send(8'hAA); send(8'h05); send(8'h02); send(8'h44);
    idle(TIMEOUT - 2);
    check("t5_busy_wait", 32'(bus.busy), 32'd1);
    send(8'h55);
    check("t5_eto", 32'(bus.err_timeout), 32'd0);
    check("t5_vbus", 32'(bus.valid_bus), 32'd1 << 5);
    check("t5_data", 32'(bus.master_data), 32'h55);
    check("t5_busy_end", 32'(bus.busy), 32'd0);
    idle(1);
    check("t5_eto_late", 32'(bus.err_timeout), 32'd0);

    // Reset between payload bytes.
    send(8'hAA); send(8'h0C); send(8'h03); send(8'h11);
    check("t6_vbus_pre", 32'(bus.valid_bus), 32'd1 << 12);
    n_rst = 1'b0;
    #1;
    check("t6_rst_vbus", 32'(bus.valid_bus), 32'd0);
    check("t6_rst_data", 32'(bus.master_data), 32'd0);
    check("t6_rst_busy", 32'(bus.busy), 32'd0);
    idle(2);
    n_rst = 1'b1;
    send(8'h22);
    check("t6_left_busy", 32'(bus.busy), 32'd0);
    send(8'h33);
    check("t6_left_vbus", 32'(bus.valid_bus), 32'd0);
    check("t6_left_busy2", 32'(bus.busy), 32'd0);
    idle(1);

    // Random mix of junk, good, bad-address and truncated packets.
    for (int k = 0; k < 60; k++) begin
      int kind;
      int a;
      int len;
      kind = int'($urandom_range(0, 9));
      if (kind <= 1) begin
        int nj;
        nj = int'($urandom_range(1, 3));
        for (int j = 0; j < nj; j++) begin
          logic [7:0] jb;
          jb = 8'($urandom_range(0, 255));
          if (jb == SYNC) jb = 8'h55;
          idle(int'($urandom_range(0, 2)));
          send(jb);
        end
      end else if (kind <= 6) begin
        a   = int'($urandom_range(0, N_ADDR - 1));
        len = int'($urandom_range(0, 6));
        rand_packet(a, len, 0, bit'($urandom_range(0, 1)));
      end else if (kind == 7) begin
        a   = int'($urandom_range(N_ADDR, 255));
        len = int'($urandom_range(0, 4));
        rand_packet(a, len, 0, bit'($urandom_range(0, 1)));
      end else begin
        a   = int'($urandom_range(0, 30));
        len = int'($urandom_range(1, 6));
        rand_packet(a, len, int'($urandom_range(1, 2 + len)), bit'($urandom_range(0, 1)));
      end
    end

    idle(5);
    check("end_queue_empty", 32'(exp_q.size()), 32'd0);
    check("end_eaddr_count", 32'(obs_eaddr), 32'(exp_eaddr));
    check("end_eto_count", 32'(obs_eto), 32'(exp_eto));
    check("end_busy", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion, want completion within time limit");
    $fatal(1);
  end

endmodule

// File: doc/cmd_parser.md
# cmd_parser

Byte-stream command parser that sits directly upstream of the FPGA control-register bank. It receives bytes from the host link, frames them into packets (sync, address, length, payload), and replays each payload byte as a one-cycle write strobe on the one-hot `valid_bus` together with `master_data`. It also detects bad addresses and stalled packets and reports them as one-cycle error pulses.

## Interface
Parameters:
- `N_ADDR`, 21: width of `valid_bus`; legal addresses are 0..N_ADDR-1.
- `SYNC`, 8'hAA: packet start byte.
- `TIMEOUT`, 50000: maximum idle clocks between bytes inside a packet.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  one-cycle qualifier for `rx_data`; may be asserted on consecutive cycles.
- `master_data`  out  8  payload byte, registered.
- `valid_bus`  out  N_ADDR  one-hot write strobe, one cycle per payload byte.
- `busy`  out  1  high while a packet is in progress (state is not IDLE).
- `err_addr`  out  1  one-cycle pulse when the address byte is >= N_ADDR.
- `err_timeout`  out  1  one-cycle pulse when a packet is aborted by timeout.

## Operation
- Packet format: SYNC, ADDR, LEN, then LEN payload bytes. LEN is 0..255.
- State machine (state changes on accepted bytes, i.e. cycles with `rx_valid`=1):
  - IDLE -> ADDR on a SYNC byte. All other bytes are discarded silently.
  - ADDR -> LEN. Latch `addr`. Set an internal `drop` flag and pulse `err_addr` if `addr` >= N_ADDR.
  - LEN -> DATA if LEN != 0, loading the 8-bit down-counter `remaining` with LEN. LEN = 0 -> IDLE; no strobe is produced.
  - DATA: each byte sets `master_data` to `rx_data`. If `drop`=0, also pulse `valid_bus[addr]`. Decrement `remaining`; when it was 1, go to IDLE.
- A SYNC value inside ADDR, LEN or DATA is ordinary data. There is no resynchronisation mid-packet.
- Dropped packets are still consumed byte-for-byte; `valid_bus` stays 0 for them.
- Timeout:
  - The inter-byte counter is cleared on every accepted byte and held at 0 in IDLE.
  - In any other state it increments each cycle without `rx_valid`.
  - When it reaches TIMEOUT-1: go to IDLE, clear `drop`, pulse `err_timeout`.
- `rx_valid` in the same cycle the counter reaches TIMEOUT-1: the byte wins. It is processed normally, the counter clears, and there is no timeout.
- `master_data` holds its last value between strobes. At most one bit of `valid_bus` is high in any cycle.

## Timing
- Reset values:
  - `master_data` = 0, `valid_bus` = 0, `busy` = 0, `err_addr` = 0, `err_timeout` = 0.
  - State = IDLE; `addr`, `remaining`, `drop` and the timeout counter = 0.
- Latency:
  - Payload byte accepted at edge k: `master_data` and `valid_bus[addr]` are valid for exactly the cycle after edge k, i.e. one registered stage.
  - `err_addr` pulses in the cycle after the ADDR byte is accepted.
  - `busy` rises the cycle after SYNC is accepted and falls the cycle after the last payload byte (or after the LEN=0 byte, or after the timeout).
- Back-to-back: a SYNC immediately following the last payload byte starts a new packet with no gap. A full-rate stream gives one strobe per cycle.
- Reset mid-packet: immediate return to IDLE and all outputs to 0. Partially received payload is abandoned, but strobes already issued remain applied downstream.

## Structure
- Shared package `cmd_parser_pkg`:
  - state enum (IDLE, ADDR, LEN, DATA);
  - `SYNC_BYTE` constant;
  - `ADDR_W` = clog2(N_ADDR).
- Sub-module `byte_timeout`:
  - inputs `clk`, `n_rst`, `clear`, `enable`;
  - output `expired`, a one-cycle pulse at TIMEOUT-1;
  - counter width clog2(TIMEOUT).
- The FSM, address/length latches and output registers stay in `cmd_parser`.

## Test plan
- AA 0B 01 05 -> one strobe on `valid_bus[11]` with `master_data`=05, one cycle after the 05 byte; `busy` high from the cycle after AA to the cycle after 05.
- AA 0C 03 11 22 33 sent on consecutive cycles -> three consecutive strobes on `valid_bus[12]` with data 11, 22, 33, followed directly by AA 0D 00 -> no strobe and `busy` low.
- 00 FF AA 15 02 01 02 (N_ADDR=21) -> leading bytes ignored; `err_addr` pulses once; no `valid_bus` activity; the next good packet AA 10 01 01 strobes bit 16.
- AA 13 02 01, then a pause of TIMEOUT cycles -> one strobe on bit 19, then `err_timeout` at pause cycle TIMEOUT-1, `busy` low; a following AA 13 01 00 works normally.
- Byte arriving on exactly cycle TIMEOUT-1 of a pause -> no `err_timeout`; the packet completes.
- `n_rst` asserted between payload bytes 1 and 2 of a 3-byte packet -> all outputs 0 immediately; after release, leftover bytes 22 33 are discarded in IDLE.
